// File: rtl/ft_rr_arb_if.sv
// Bundle of the requester faces (flow-through FIFO valid/data/last/pop) and
// the registered output handshake shared by the arbiter and its neighbours.
interface ft_rr_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int SRC_W      = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_pop;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_last;
    logic [SRC_W-1:0]              out_src;
    logic                          out_ready;

    // Arbiter side: consumes requester faces, drives pops and the output beat.
    modport master (
        input  req_valid, req_data, req_last, out_ready,
        output req_pop, out_valid, out_data, out_last, out_src
    );

    // Environment side: upstream FIFOs and the downstream consumer.
    modport slave (
        output req_valid, req_data, req_last, out_ready,
        input  req_pop, out_valid, out_data, out_last, out_src
    );
endinterface

// File: rtl/ft_rr_arb.sv
// Round-robin arbiter that pops one flow-through FIFO per cycle into a single
// registered output stage. With PKT_LOCK set, a grant is held from the first
// beat of a packet until its last beat so packets never interleave.
module ft_rr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LOCK   = 1,
    parameter int SRC_W      = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    ft_rr_arb_if.master   bus,
    output logic          locked
);

    // Requester slots padded up to a power of two so any SRC_W-bit index is
    // in range; absent slots read as never valid.
    localparam int               NSLOT     = 1 << SRC_W;
    localparam logic [SRC_W-1:0] LAST_IDX  = SRC_W'(NUM_REQ - 1);
    localparam logic [SRC_W:0]   NUM_REQ_W = (SRC_W + 1)'(NUM_REQ);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [SRC_W-1:0]      r_lock_src;
    logic [SRC_W-1:0]      w_lock_src_next;
    logic [SRC_W-1:0]      r_rr_ptr;
    logic [SRC_W-1:0]      w_rr_ptr_next;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_last;
    logic [SRC_W-1:0]      r_out_src;

    logic [NSLOT-1:0]      w_valid_pad;
    logic [NSLOT-1:0]      w_last_pad;
    logic [DATA_WIDTH-1:0] w_data_pad [NSLOT];
    logic [SRC_W-1:0]      w_cand [NUM_REQ];

    logic                  w_arb_found;
    logic [SRC_W-1:0]      w_arb_idx;
    logic [SRC_W-1:0]      w_grant;
    logic                  w_have;
    logic                  w_load;
    logic                  w_fire;
    logic                  w_beat_last;

    genvar gi;

    // Map the flat requester buses onto padded per-slot views.
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < NUM_REQ) begin : g_real
                assign w_valid_pad[gi] = bus.req_valid[gi];
                assign w_last_pad[gi]  = bus.req_last[gi];
                assign w_data_pad[gi]  = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_absent
                assign w_valid_pad[gi] = 1'b0;
                assign w_last_pad[gi]  = 1'b0;
                assign w_data_pad[gi]  = '0;
            end
        end
    endgenerate

    // Candidate order rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ (not at 2**SRC_W).
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [SRC_W:0] w_sum;
            assign w_sum       = {1'b0, r_rr_ptr} + (SRC_W + 1)'(gi);
            assign w_cand[gi]  = (w_sum >= NUM_REQ_W) ? SRC_W'(w_sum - NUM_REQ_W)
                                                      : w_sum[SRC_W-1:0];
        end
    endgenerate

    // First valid candidate in rotated order; scanning downward lets the
    // lowest offset win.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_valid_pad[w_cand[k]]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_cand[k];
            end
        end
    end

    // While locked only the packet owner may be served, even if it is empty.
    assign w_grant     = (r_state == ST_LOCKED) ? r_lock_src : w_arb_idx;
    assign w_have      = (r_state == ST_LOCKED) ? w_valid_pad[r_lock_src] : w_arb_found;
    assign w_load      = !r_out_valid || bus.out_ready;
    assign w_fire      = rst_n && w_load && w_have;
    assign w_beat_last = w_last_pad[w_grant];

    // One-hot combinational pop to the granted FIFO.
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_pop
            assign bus.req_pop[gi] = w_fire && (w_grant == SRC_W'(gi));
        end
    endgenerate

    // Next lock state and pointer: advance the pointer only when a grant ends.
    always_comb begin
        w_state_next    = r_state;
        w_lock_src_next = r_lock_src;
        w_rr_ptr_next   = r_rr_ptr;
        if (w_fire) begin
            if ((PKT_LOCK != 0) && !w_beat_last) begin
                w_state_next    = ST_LOCKED;
                w_lock_src_next = w_grant;
            end else begin
                w_state_next  = ST_IDLE;
                w_rr_ptr_next = (w_grant == LAST_IDX) ? '0 : w_grant + SRC_W'(1);
            end
        end
    end

    // Lock state, lock owner and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_lock_src <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_lock_src <= w_lock_src_next;
            r_rr_ptr   <= w_rr_ptr_next;
        end
    end

    // Output stage: refill whenever empty or being drained, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= '0;
        end else if (w_load) begin
            r_out_valid <= w_fire;
            if (w_fire) begin
                r_out_data <= w_data_pad[w_grant];
                r_out_last <= w_beat_last;
                r_out_src  <= w_grant;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_src   = r_out_src;
    assign locked        = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_ft_rr_arb.sv
// Directed bench for ft_rr_arb: a 4-way non-locking instance, a 4-way
// packet-locking instance and a 3-way packet-locking instance share clk/rst_n.
module tb_ft_rr_arb;

    logic clk = 1'b0;
    logic rst_n;
    logic locked0, locked1, locked2;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ft_rr_arb_if #(.NUM_REQ(4), .DATA_WIDTH(32), .SRC_W(2)) b0 ();
    ft_rr_arb_if #(.NUM_REQ(4), .DATA_WIDTH(32), .SRC_W(2)) b1 ();
    ft_rr_arb_if #(.NUM_REQ(3), .DATA_WIDTH(32), .SRC_W(2)) b2 ();

    ft_rr_arb #(.NUM_REQ(4), .DATA_WIDTH(32), .PKT_LOCK(0), .SRC_W(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0.master), .locked(locked0));
    ft_rr_arb #(.NUM_REQ(4), .DATA_WIDTH(32), .PKT_LOCK(1), .SRC_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.master), .locked(locked1));
    ft_rr_arb #(.NUM_REQ(3), .DATA_WIDTH(32), .PKT_LOCK(1), .SRC_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2.master), .locked(locked2));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        b0.out_ready = 1'b1; b1.out_ready = 1'b1; b2.out_ready = 1'b1;
        b0.req_valid = 4'hF; b1.req_valid = 4'hF; b2.req_valid = 3'h7;
        b0.req_last  = 4'hF; b1.req_last  = 4'hF; b2.req_last  = 3'h7;
        b0.req_data  = '0;   b1.req_data  = '0;   b2.req_data  = '0;
        tick();
        tick();
        checks++;
        if ({b0.out_valid, b1.out_valid, b2.out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_out_valid got=%b exp=000", {b0.out_valid, b1.out_valid, b2.out_valid});
        end
        checks++;
        if ({locked0, locked1, locked2} !== 3'b000) begin
            errors++;
            $display("FAIL reset_locked got=%b exp=000", {locked0, locked1, locked2});
        end
        checks++;
        if (b1.out_src !== 2'd0 || b1.out_data !== 32'h0 || b1.out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_fields got src=%0d data=%h last=%b exp src=0 data=0 last=0",
                     b1.out_src, b1.out_data, b1.out_last);
        end
        checks++;
        if (b0.req_pop !== 4'b0 || b1.req_pop !== 4'b0 || b2.req_pop !== 3'b0) begin
            errors++;
            $display("FAIL reset_pop got=%b/%b/%b exp=0000/0000/000", b0.req_pop, b1.req_pop, b2.req_pop);
        end
        $display("reset: outputs and pops checked");
        b0.req_valid = '0; b1.req_valid = '0; b2.req_valid = '0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_rr_no_lock;
        logic [3:0]  exp_pop;
        logic [1:0]  exp_src;
        logic [31:0] exp_data;
        b0.req_data  = {32'h0000_00D3, 32'h0000_00D2, 32'h0000_00D1, 32'h0000_00D0};
        b0.req_last  = 4'hF;
        b0.req_valid = 4'hF;
        b0.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_pop  = 4'b0001 << (k % 4);
            exp_src  = 2'(k % 4);
            exp_data = 32'h0000_00D0 + 32'(k % 4);
            settle();
            checks++;
            if (b0.req_pop !== exp_pop) begin
                errors++;
                $display("FAIL rr_pop[%0d] got=%b exp=%b", k, b0.req_pop, exp_pop);
            end
            tick();
            checks++;
            if (b0.out_valid !== 1'b1 || b0.out_src !== exp_src || b0.out_data !== exp_data) begin
                errors++;
                $display("FAIL rr_beat[%0d] got v=%b src=%0d data=%h exp v=1 src=%0d data=%h",
                         k, b0.out_valid, b0.out_src, b0.out_data, exp_src, exp_data);
            end
            $display("rr beat %0d: src=%0d data=%h", k, b0.out_src, b0.out_data);
        end
    endtask

    task automatic test_backpressure;
        b0.out_ready = 1'b0;
        settle();
        checks++;
        if (b0.req_pop !== 4'b0000) begin
            errors++;
            $display("FAIL bp_pop_first got=%b exp=0000", b0.req_pop);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (b0.out_valid !== 1'b1 || b0.out_src !== 2'd1 || b0.out_data !== 32'h0000_00D1 ||
                b0.req_pop !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b src=%0d data=%h pop=%b exp v=1 src=1 data=000000d1 pop=0000",
                         k, b0.out_valid, b0.out_src, b0.out_data, b0.req_pop);
            end
            $display("bp stall %0d: src=%0d data=%h", k, b0.out_src, b0.out_data);
        end
        b0.out_ready = 1'b1;
        settle();
        checks++;
        if (b0.req_pop !== 4'b0100) begin
            errors++;
            $display("FAIL bp_release_pop got=%b exp=0100", b0.req_pop);
        end
        tick();
        checks++;
        if (b0.out_valid !== 1'b1 || b0.out_src !== 2'd2 || b0.out_data !== 32'h0000_00D2) begin
            errors++;
            $display("FAIL bp_release_beat got v=%b src=%0d data=%h exp v=1 src=2 data=000000d2",
                     b0.out_valid, b0.out_src, b0.out_data);
        end
        b0.req_valid = 4'h0;
        settle();
        tick();
        checks++;
        if (b0.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got v=%b exp=0", b0.out_valid);
        end
        $display("bp: released and drained");
    endtask

    task automatic test_pkt_lock;
        b1.out_ready = 1'b1;
        b1.req_data[1*32 +: 32] = 32'h1100_0001;
        b1.req_last[1] = 1'b0;
        b1.req_data[2*32 +: 32] = 32'h2200_0000;
        b1.req_last[2] = 1'b1;
        b1.req_valid = 4'b0110;
        for (int beat = 1; beat <= 3; beat++) begin
            settle();
            checks++;
            if (b1.req_pop !== 4'b0010) begin
                errors++;
                $display("FAIL lock_pop[%0d] got=%b exp=0010", beat, b1.req_pop);
            end
            tick();
            checks++;
            if (b1.out_valid !== 1'b1 || b1.out_src !== 2'd1 ||
                b1.out_data !== 32'h1100_0000 + 32'(beat) ||
                b1.out_last !== (beat == 3) || locked1 !== (beat < 3)) begin
                errors++;
                $display("FAIL lock_beat[%0d] got v=%b src=%0d data=%h last=%b locked=%b exp v=1 src=1 data=%h last=%b locked=%b",
                         beat, b1.out_valid, b1.out_src, b1.out_data, b1.out_last, locked1,
                         32'h1100_0000 + 32'(beat), (beat == 3), (beat < 3));
            end
            $display("lock beat %0d: src=%0d data=%h locked=%b", beat, b1.out_src, b1.out_data, locked1);
            if (beat < 3) begin
                b1.req_data[1*32 +: 32] = 32'h1100_0000 + 32'(beat + 1);
                b1.req_last[1] = (beat + 1 == 3);
            end else begin
                b1.req_valid = 4'b0100;
            end
        end
        settle();
        checks++;
        if (b1.req_pop !== 4'b0100) begin
            errors++;
            $display("FAIL lock_next_pop got=%b exp=0100", b1.req_pop);
        end
        tick();
        checks++;
        if (b1.out_src !== 2'd2 || b1.out_data !== 32'h2200_0000 || locked1 !== 1'b0) begin
            errors++;
            $display("FAIL lock_next_beat got src=%0d data=%h locked=%b exp src=2 data=22000000 locked=0",
                     b1.out_src, b1.out_data, locked1);
        end
        $display("lock next: src=%0d data=%h", b1.out_src, b1.out_data);
        b1.req_valid = 4'b0000;
        settle();
        tick();
    endtask

    task automatic test_stall_in_packet;
        // pointer is 3 here: req0 would win if req1 were not holding the lock
        b1.req_data[0*32 +: 32] = 32'h4400_0000;
        b1.req_last[0] = 1'b1;
        b1.req_data[1*32 +: 32] = 32'h3300_0001;
        b1.req_last[1] = 1'b0;
        b1.req_valid = 4'b0010;
        settle();
        checks++;
        if (b1.req_pop !== 4'b0010) begin
            errors++;
            $display("FAIL stall_first_pop got=%b exp=0010", b1.req_pop);
        end
        tick();
        $display("stall beat 1: src=%0d data=%h locked=%b", b1.out_src, b1.out_data, locked1);
        b1.req_valid = 4'b0001;
        for (int k = 0; k < 2; k++) begin
            settle();
            checks++;
            if (b1.req_pop !== 4'b0000) begin
                errors++;
                $display("FAIL stall_pop[%0d] got=%b exp=0000", k, b1.req_pop);
            end
            tick();
            checks++;
            if (b1.out_valid !== 1'b0 || locked1 !== 1'b1) begin
                errors++;
                $display("FAIL stall_bubble[%0d] got v=%b locked=%b exp v=0 locked=1", k, b1.out_valid, locked1);
            end
            $display("stall bubble %0d: v=%b", k, b1.out_valid);
        end
        b1.req_valid = 4'b0011;
        for (int beat = 2; beat <= 3; beat++) begin
            b1.req_data[1*32 +: 32] = 32'h3300_0000 + 32'(beat);
            b1.req_last[1] = (beat == 3);
            settle();
            checks++;
            if (b1.req_pop !== 4'b0010) begin
                errors++;
                $display("FAIL stall_resume_pop[%0d] got=%b exp=0010", beat, b1.req_pop);
            end
            tick();
            checks++;
            if (b1.out_valid !== 1'b1 || b1.out_src !== 2'd1 ||
                b1.out_data !== 32'h3300_0000 + 32'(beat) || locked1 !== (beat < 3)) begin
                errors++;
                $display("FAIL stall_resume_beat[%0d] got v=%b src=%0d data=%h locked=%b exp v=1 src=1 data=%h locked=%b",
                         beat, b1.out_valid, b1.out_src, b1.out_data, locked1,
                         32'h3300_0000 + 32'(beat), (beat < 3));
            end
            $display("stall beat %0d: src=%0d data=%h", beat, b1.out_src, b1.out_data);
        end
        b1.req_valid = 4'b0001;
        settle();
        checks++;
        if (b1.req_pop !== 4'b0001) begin
            errors++;
            $display("FAIL stall_after_pop got=%b exp=0001", b1.req_pop);
        end
        tick();
        checks++;
        if (b1.out_src !== 2'd0 || b1.out_data !== 32'h4400_0000) begin
            errors++;
            $display("FAIL stall_after_beat got src=%0d data=%h exp src=0 data=44000000", b1.out_src, b1.out_data);
        end
        $display("stall after: src=%0d data=%h", b1.out_src, b1.out_data);
        b1.req_valid = 4'b0000;
        settle();
        tick();
    endtask

    task automatic test_reset_mid_packet;
        // pointer is 1 here; a lost reset would leave req1 locked or req3 favoured
        b1.req_data[1*32 +: 32] = 32'h5500_0001;
        b1.req_last[1] = 1'b0;
        b1.req_valid = 4'b0010;
        settle();
        tick();
        checks++;
        if (locked1 !== 1'b1 || b1.out_src !== 2'd1) begin
            errors++;
            $display("FAIL rstmid_lock got locked=%b src=%0d exp locked=1 src=1", locked1, b1.out_src);
        end
        rst_n = 1'b0;
        settle();
        checks++;
        if (b1.req_pop !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_pop_gate got=%b exp=0000", b1.req_pop);
        end
        tick();
        checks++;
        if (b1.out_valid !== 1'b0 || locked1 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_cleared got v=%b locked=%b exp v=0 locked=0", b1.out_valid, locked1);
        end
        rst_n = 1'b1;
        b1.req_data[0*32 +: 32] = 32'h6600_0000;
        b1.req_data[3*32 +: 32] = 32'h6600_0003;
        b1.req_last = 4'b1001;
        b1.req_valid = 4'b1001;
        settle();
        checks++;
        if (b1.req_pop !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_first_pop got=%b exp=0001", b1.req_pop);
        end
        tick();
        checks++;
        if (b1.out_src !== 2'd0 || b1.out_data !== 32'h6600_0000 || locked1 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_first_beat got src=%0d data=%h locked=%b exp src=0 data=66000000 locked=0",
                     b1.out_src, b1.out_data, locked1);
        end
        $display("rstmid beat: src=%0d data=%h", b1.out_src, b1.out_data);
        b1.req_valid = 4'b1000;
        settle();
        tick();
        checks++;
        if (b1.out_src !== 2'd3 || b1.out_data !== 32'h6600_0003) begin
            errors++;
            $display("FAIL rstmid_second_beat got src=%0d data=%h exp src=3 data=66000003", b1.out_src, b1.out_data);
        end
        $display("rstmid beat: src=%0d data=%h", b1.out_src, b1.out_data);
        b1.req_valid = 4'b0000;
        settle();
        tick();
    endtask

    task automatic test_non_pow2;
        b2.out_ready = 1'b1;
        b2.req_last  = 3'b111;
        b2.req_data  = {32'h7700_0002, 32'h7700_0001, 32'h7700_0000};
        b2.req_valid = 3'b100;
        for (int k = 0; k < 5; k++) begin
            settle();
            checks++;
            if (b2.req_pop !== 3'b100) begin
                errors++;
                $display("FAIL np2_pop[%0d] got=%b exp=100", k, b2.req_pop);
            end
            tick();
            checks++;
            if (b2.out_valid !== 1'b1 || b2.out_src !== 2'd2 || b2.out_data !== 32'h7700_0002) begin
                errors++;
                $display("FAIL np2_beat[%0d] got v=%b src=%0d data=%h exp v=1 src=2 data=77000002",
                         k, b2.out_valid, b2.out_src, b2.out_data);
            end
            $display("np2 beat %0d: src=%0d", k, b2.out_src);
        end
        // pointer wrapped to 0 after req2, so req0 wins, then req2 again
        b2.req_valid = 3'b101;
        settle();
        checks++;
        if (b2.req_pop !== 3'b001) begin
            errors++;
            $display("FAIL np2_wrap_pop got=%b exp=001", b2.req_pop);
        end
        tick();
        settle();
        checks++;
        if (b2.out_src !== 2'd0 || b2.req_pop !== 3'b100) begin
            errors++;
            $display("FAIL np2_wrap_next got src=%0d pop=%b exp src=0 pop=100", b2.out_src, b2.req_pop);
        end
        $display("np2 wrap: src=%0d", b2.out_src);
        tick();
        checks++;
        if (b2.out_src !== 2'd2) begin
            errors++;
            $display("FAIL np2_wrap_beat got src=%0d exp src=2", b2.out_src);
        end
        b2.req_valid = 3'b000;
        settle();
        tick();
    endtask

    initial begin
        test_reset();
        test_rr_no_lock();
        test_backpressure();
        test_pkt_lock();
        test_stall_in_packet();
        test_reset_mid_packet();
        test_non_pow2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
